// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding, FSM states and
// op-decode helpers.
package muldiv_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHU  = 3'b010;
    localparam logic [2:0] OP_MULRSV = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Upper half of the double-width product; reserved 011 falls through to MUL.
    function automatic logic op_is_high(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling for signed multiply/divide: strips operand signs on entry and
// negates the double-width raw result on exit.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic              sgn,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   abs_a,
    output logic [XLEN-1:0]   abs_b,
    output logic              neg_a,
    output logic              neg_b,
    input  logic [2*XLEN-1:0] res_in,
    input  logic              res_neg,
    output logic [2*XLEN-1:0] res_out
);

    assign neg_a = sgn & a[XLEN-1];
    assign neg_b = sgn & b[XLEN-1];

    // The magnitude of the most negative value wraps to itself, which is the correct
    // unsigned magnitude.
    assign abs_a = neg_a ? ('0 - a) : a;
    assign abs_b = neg_b ? ('0 - b) : b;

    assign res_out = res_neg ? ('0 - res_in) : res_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// single register-file write on completion. Signed ops enabled by MULDIV_SIGNED_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    input  logic            kill,
    output logic            busy,
    output logic            wb_valid,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    state_e            state;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              busy_q;
    logic              wb_valid_q;
    logic [4:0]        wb_reg_q;
    logic [XLEN-1:0]   wb_data_q;

    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic              div_zero;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] res_raw;
    logic [2*XLEN-1:0] res_fix;
    logic [XLEN-1:0]   result;

`ifdef MULDIV_SIGNED_EN
    logic op_sgn;
    logic neg_a;
    logic neg_b;
    logic start_neg;
    logic neg_q;

    assign op_sgn = op_is_signed(op);

    muldiv_sign_fix #(
        .XLEN(XLEN)
    ) u_sign_fix (
        .sgn     (op_sgn),
        .a       (rs1_data),
        .b       (rs2_data),
        .abs_a   (opa),
        .abs_b   (opb),
        .neg_a   (neg_a),
        .neg_b   (neg_b),
        .res_in  (res_raw),
        .res_neg (neg_q),
        .res_out (res_fix)
    );

    // Quotient and product flip when signs differ; remainder follows the dividend.
    assign start_neg = op_is_rem(op) ? neg_a : (neg_a ^ neg_b);
`else
    assign opa     = rs1_data;
    assign opb     = rs2_data;
    assign res_fix = res_raw;
`endif

    assign div_zero = op_is_div(op) && (rs2_data == '0);

    // Multiply: {hi, lo} shifts right, multiplier bits consumed from lo[0].
    assign mul_sum = {1'b0, hi} + ({1'b0, opnd} & {(XLEN + 1){lo[0]}});

    // Divide: partial remainder in hi, dividend shifts out of lo as quotient bits shift in.
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[XLEN-1:0] - opnd;

    always_comb begin
        hi_n = '0;
        lo_n = '0;
        if (op_is_div(op_q)) begin
            hi_n = div_ge ? div_sub : div_shift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Result is formed from the final step's values so it can be registered entering FIN.
    assign res_raw = op_is_div(op_q) ?
                     {{XLEN{1'b0}}, (op_is_rem(op_q) ? hi_n : lo_n)} : {hi_n, lo_n};
    assign result  = op_is_high(op_q) ? res_fix[2*XLEN-1:XLEN] : res_fix[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            count      <= '0;
            op_q       <= OP_MUL;
            rd_q       <= '0;
            opnd       <= '0;
            hi         <= '0;
            lo         <= '0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else if (kill) begin
            state      <= S_IDLE;
            count      <= '0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    wb_valid_q <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        rd_q   <= rd;
                        busy_q <= 1'b1;
                        if (div_zero) begin
                            state      <= S_FIN;
                            wb_valid_q <= (rd != 5'd0);
                            wb_reg_q   <= rd;
                            wb_data_q  <= op_is_rem(op) ? rs1_data : '1;
                        end else begin
                            state <= S_CALC;
                            count <= CNT_W'(XLEN);
                            hi    <= '0;
                            opnd  <= op_is_div(op) ? opb : opa;
                            lo    <= op_is_div(op) ? opa : opb;
`ifdef MULDIV_SIGNED_EN
                            neg_q <= start_neg;
`endif
                        end
                    end
                end
                S_CALC: begin
                    hi    <= hi_n;
                    lo    <= lo_n;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state      <= S_FIN;
                        wb_valid_q <= (rd_q != 5'd0);
                        wb_reg_q   <= rd_q;
                        wb_data_q  <= result;
                    end
                end
                S_FIN: begin
                    state      <= S_IDLE;
                    busy_q     <= 1'b0;
                    wb_valid_q <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    busy_q     <= 1'b0;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    // A flush arriving in the FIN cycle must still suppress the write.
    assign wb_valid = wb_valid_q & ~kill;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus hand-written kill/reset/busy sequences,
// with a scoreboard of expected register-file writes.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int          LAT  = XLEN + 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            kill;
    logic            busy;
    logic            wb_valid;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN(XLEN)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd       (rd),
        .kill     (kill),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];
    wb_t  mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h, expected no write",
                         wb_reg, wb_data);
            end else begin
                mon_e = sb.pop_front();
                check("wb_reg", 64'(wb_reg), 64'(mon_e.rd));
                check("wb_data", 64'(wb_data), 64'(mon_e.data));
            end
        end
    end

    task automatic add_vec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input logic [31:0] exp);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.b   = b;
        v.rd  = r;
        v.exp = exp;
        v.lat = (o[2] && b == 32'd0) ? 1 : LAT;
        vecs.push_back(v);
    endtask

    // Drive one start; returns just after the accepting edge (inside cycle T+1).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp, input bit expect_wr);
        wb_t e;
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd       = r;
        if (expect_wr) begin
            e.rd   = r;
            e.data = exp;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd       = 5'($urandom);
    endtask

    task automatic wait_done(input int busy_exp, input int wb_exp, input string name);
        int nbusy = 0;
        int seen  = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (wb_valid === 1'b1 && seen == 0) seen = c;
            if (busy !== 1'b1) break;
            nbusy++;
        end
        check({name, " busy_cycles"}, 64'(nbusy), 64'(busy_exp));
        check({name, " wb_cycle"}, 64'(seen), 64'(wb_exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] p;
        logic [31:0] da;
        logic [31:0] db;

        rstn = 1'b0; start = 1'b0; kill = 1'b0; op = OP_MUL;
        rs1_data = '0; rs2_data = '0; rd = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset wb_valid", 64'(wb_valid), 64'd0);
        check("reset wb_reg", 64'(wb_reg), 64'd0);
        check("reset wb_data", 64'(wb_data), 64'd0);

        p  = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        da = 32'hDEAD_BEEF;
        db = 32'h0000_1234;
        add_vec(OP_MUL,    32'd7,         32'd6,         5'd5,  32'd42);
        add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
        add_vec(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0001);
        add_vec(OP_DIVU,   32'd100,       32'd7,         5'd3,  32'd14);
        add_vec(OP_REMU,   32'd100,       32'd7,         5'd4,  32'd2);
        add_vec(OP_DIVU,   32'd5,         32'd0,         5'd6,  32'hFFFF_FFFF);
        add_vec(OP_REMU,   32'd5,         32'd0,         5'd7,  32'd5);
        add_vec(OP_MULRSV, 32'd7,         32'd6,         5'd8,  32'd42);
        add_vec(OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 5'd9,  p[31:0]);
        add_vec(OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 5'd10, p[63:32]);
        add_vec(OP_DIVU,   32'hFFFF_FFFF, 32'h10,        5'd11, 32'h0FFF_FFFF);
        add_vec(OP_REMU,   32'hFFFF_FFFF, 32'h10,        5'd12, 32'hF);
        add_vec(OP_DIVU,   32'd3,         32'd5,         5'd13, 32'd0);
        add_vec(OP_REMU,   32'd3,         32'd5,         5'd14, 32'd3);
        add_vec(OP_DIVU,   da,            db,            5'd17, da / db);
        add_vec(OP_REMU,   da,            db,            5'd18, da % db);
`ifdef MULDIV_SIGNED_EN
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd20, 32'hFFFF_FFFD);
        add_vec(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd21, 32'hFFFF_FFFF);
        add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000);
        add_vec(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0);
        add_vec(OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd24, 32'hFFFF_FFFD);
        add_vec(OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd25, 32'd1);
        add_vec(OP_MULH, 32'hFFFF_FFFD, 32'd5,         5'd26, 32'hFFFF_FFFF);
        add_vec(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd27, 32'h4000_0000);
        add_vec(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd28, 32'd0);
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd0,         5'd29, 32'hFFFF_FFFF);
        add_vec(OP_REM,  32'hFFFF_FFF9, 32'd0,         5'd30, 32'hFFFF_FFF9);
`else
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd20, 32'h7FFF_FFFC);
        add_vec(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd21, 32'd1);
        add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0);
        add_vec(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h8000_0000);
        add_vec(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd26, 32'hFFFF_FFFE);
        add_vec(OP_DIV,  32'd5,         32'd0,         5'd29, 32'hFFFF_FFFF);
        add_vec(OP_REM,  32'd5,         32'd0,         5'd30, 32'd5);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
            wait_done(vecs[i].lat, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // rd=0: full latency, no write.
        issue(OP_MUL, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0);
        wait_done(LAT, 0, "rd0_mul");

        // Start while busy is ignored; only the first operation writes.
        issue(OP_MUL, 32'd7, 32'd6, 5'd10, 32'd42, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_MUL; rs1_data = 32'd2; rs2_data = 32'd2; rd = 5'd11;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(LAT - 5, LAT - 5, "busy_start");
        repeat (40) @(negedge clk);

        // Kill during CALC at T+10.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd12, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill busy", 64'(busy), 64'd0);
        check("kill wb_valid", 64'(wb_valid), 64'd0);
        issue(OP_MUL, 32'd7, 32'd6, 5'd13, 32'd42, 1'b1);
        wait_done(LAT, LAT, "after_kill");

        // Kill overrides a simultaneous start.
        @(posedge clk);
        #1;
        start = 1'b1; kill = 1'b1; op = OP_MUL; rs1_data = 32'd4; rs2_data = 32'd4; rd = 5'd14;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_vs_start busy", 64'(busy), 64'd0);

        // Kill in the FIN cycle gates wb_valid combinationally.
        issue(OP_MUL, 32'd5, 32'd5, 5'd15, 32'd25, 1'b0);
        repeat (32) @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        check("fin_kill busy", 64'(busy), 64'd1);
        check("fin_kill wb_valid", 64'(wb_valid), 64'd0);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("fin_kill busy_after", 64'(busy), 64'd0);

        // Reset mid-divide at T+20.
        issue(OP_DIVU, 32'd12345, 32'd7, 5'd16, 32'd0, 1'b0);
        repeat (19) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst wb_valid", 64'(wb_valid), 64'd0);
        check("midrst wb_reg", 64'(wb_reg), 64'd0);
        check("midrst wb_data", 64'(wb_data), 64'd0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
